// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: command-driven stepping controller for a binary position counter
// with a registered, glitch-free Gray-coded image of the position.
module gray_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    input  logic             clr,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] steps_left,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d, steps_q, steps_d;
    logic [DIV_W-1:0] div_q, div_d, pre_q, pre_d;
    logic             dir_q, dir_d, aborted_q, aborted_d;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        steps_d   = steps_q;
        div_d     = div_q;
        dir_d     = dir_q;
        pre_d     = pre_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (clr) bin_d = '0;
                if (cmd_valid) begin
                    dir_d     = cmd_dir;
                    div_d     = cmd_div;
                    steps_d   = cmd_steps;
                    pre_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = (cmd_steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // abort wins over a coinciding prescaler match: position stays frozen
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (pre_q == div_q) begin
                    pre_d   = '0;
                    bin_d   = dir_q ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
                    steps_d = steps_q - WIDTH'(1);
                    if (steps_q == WIDTH'(1)) state_d = DONE;
                end else begin
                    pre_d = pre_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Gray is encoded from the next binary value so both registers update together
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            gray_q    <= '0;
            steps_q   <= '0;
            div_q     <= '0;
            dir_q     <= 1'b0;
            pre_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            steps_q   <= steps_d;
            div_q     <= div_d;
            dir_q     <= dir_d;
            pre_q     <= pre_d;
            aborted_q <= aborted_d;
        end
    end

    assign bin_out    = bin_q;
    assign gray_out   = gray_q;
    assign steps_left = steps_q;
    assign aborted    = aborted_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign cmd_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed and randomized commands checked against a timing
// model derived from step count, divider and abort edge arithmetic.
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0, clr = 1'b0;
    logic [7:0] cmd_steps = '0, cmd_div = '0;
    logic       cmd_ready, busy, done, aborted;
    logic [7:0] bin_out, gray_out, steps_left;

    int total = 0;
    int bad = 0;
    int pos = 0;

    gray_seq_ctrl #(.WIDTH(8), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_div(cmd_div),
        .abort(abort), .clr(clr), .bin_out(bin_out), .gray_out(gray_out),
        .steps_left(steps_left), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int b, input int sl, input int bz,
                           input int dn, input int rdy, input int ab);
        chk({tag, ".bin"}, int'(bin_out), b);
        chk({tag, ".gray"}, int'(gray_out), b ^ (b >> 1));
        chk({tag, ".steps_left"}, int'(steps_left), sl);
        chk({tag, ".busy"}, int'(busy), bz);
        chk({tag, ".done"}, int'(done), dn);
        chk({tag, ".cmd_ready"}, int'(cmd_ready), rdy);
        chk({tag, ".aborted"}, int'(aborted), ab);
    endtask

    // a: edge index (after accept) at which abort is sampled, 0 = no abort
    task automatic do_cmd(input int n, input int d, input int dv, input int a,
                          input int hold, input int wclr);
        int start, e, k, b, prevb, prevg;
        start = wclr ? 0 : pos;
        chk("pre.cmd_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_steps = 8'(n);
        cmd_dir   = d[0];
        cmd_div   = 8'(dv);
        clr       = wclr[0];
        abort     = 1'b0;
        e = (n == 0) ? 0 : (a > 0 ? a : n * (dv + 1));
        prevb = start;
        prevg = start ^ (start >> 1);
        for (int c = 0; c <= e + 1; c++) begin
            tick();
            k = (a > 0 && c >= a) ? (a - 1) / (dv + 1) : c / (dv + 1);
            if (k > n) k = n;
            b = (((start + (d != 0 ? k : -k)) % 256) + 256) % 256;
            chk_all($sformatf("cmd n=%0d d=%0d div=%0d c=%0d", n, d, dv, c), b, n - k,
                    int'(c < e), int'(c == e), int'(c > e), int'(a > 0 && c >= a));
            if (b != prevb) chk("gray.onebit", $countones(gray_out ^ 8'(prevg)), 1);
            prevb = b;
            prevg = int'(gray_out);
            cmd_valid = (hold != 0) && c < e;
            cmd_steps = 8'(~n);
            clr       = (hold != 0) && c < e;
            abort     = (a > 0) ? (c == a - 1) : (c >= e);
        end
        pos = prevb;
        cmd_valid = 1'b0;
        clr = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("idle_clr.bin", int'(bin_out), 0);
        chk("idle_clr.gray", int'(gray_out), 0);
        chk("idle_clr.busy", int'(busy), 0);
        pos = 0;
    endtask

    initial begin
        int n, dv, a;
        #2;
        chk_all("reset", 0, 0, 0, 0, 1, 0);
        #10 rst = 1'b1;
        tick();
        chk_all("post_reset", 0, 0, 0, 0, 1, 0);

        do_cmd(5, 1, 0, 0, 0, 0);
        idle_clr();
        do_cmd(1, 0, 0, 0, 0, 0);
        chk("wrap_down", pos, 8'hFF);
        do_cmd(1, 1, 0, 0, 0, 0);
        chk("wrap_up", pos, 0);
        do_cmd(2, 1, 3, 0, 0, 0);
        idle_clr();
        do_cmd(10, 1, 0, 4, 1, 0);
        do_cmd(0, 1, 2, 0, 0, 0);
        idle_clr();
        do_cmd(5, 1, 0, 0, 0, 0);
        idle_clr();
        do_cmd(3, 0, 1, 0, 0, 1);
        do_cmd(4, 1, 0, 1, 0, 0);

        for (int i = 0; i < 30; i++) begin
            n  = $urandom_range(0, 12);
            dv = $urandom_range(0, 3);
            a  = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n * (dv + 1)) : 0;
            do_cmd(n, $urandom_range(0, 1), dv, a, $urandom_range(0, 1),
                   int'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 5) == 0) idle_clr();
        end

        idle_clr();
        do_cmd(3, 1, 0, 0, 0, 0);
        cmd_valid = 1'b1;
        cmd_steps = 8'd10;
        cmd_dir   = 1'b1;
        cmd_div   = 8'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_run.busy", int'(busy), 1);
        chk("mid_run.bin", int'(bin_out), 4);
        #2 rst = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 1, 0);
        #3 rst = 1'b1;
        pos = 0;
        tick();
        do_cmd(3, 1, 1, 0, 0, 0);
        chk("final_pos", pos, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
